// File: rtl/cosim_commit_arbiter.sv
// Merges per-hart retire streams into one ordered commit stream for co-simulation.
// Each hart has a small FIFO; a round-robin arbiter feeds a single output register slice.
module cosim_commit_arbiter #(
  parameter int NUM_HARTS     = 2,
  parameter int DEPTH         = 4,
  parameter bit STALL_ON_FULL = 1'b1,
  localparam int HW           = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_HARTS-1:0]   commit_valid_i,
  output logic [NUM_HARTS-1:0]   commit_ready_o,
  input  logic [NUM_HARTS*64-1:0] commit_pc_i,
  input  logic [NUM_HARTS*64-1:0] commit_data_i,
  input  logic [NUM_HARTS*5-1:0] commit_dst_i,
  input  logic [NUM_HARTS-1:0]   commit_xcpt_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [HW-1:0]          out_hart_o,
  output logic [63:0]            out_pc_o,
  output logic [63:0]            out_data_o,
  output logic [4:0]             out_dst_o,
  output logic                   out_xcpt_o,
  output logic [15:0]            out_seq_o,
  output logic [NUM_HARTS-1:0]   overflow_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] data;
    logic [4:0]  dst;
    logic        xcpt;
    logic [15:0] seq;
  } rec_t;

  rec_t                 fifo_mem [NUM_HARTS][DEPTH];
  logic [PW-1:0]        wr_ptr   [NUM_HARTS];
  logic [PW-1:0]        rd_ptr   [NUM_HARTS];
  logic [15:0]          seq_cnt  [NUM_HARTS];
  logic [NUM_HARTS-1:0] full, empty, push, drop, seq_inc, pop;
  logic [HW-1:0]        prio, gnt_idx;
  logic                 gnt_vld, load;
  rec_t                 rec_p1;
  logic [HW-1:0]        hart_p1;
  logic                 vld_p1;

  function automatic logic [HW-1:0] next_idx(input logic [HW-1:0] idx);
    return (idx == HW'(NUM_HARTS - 1)) ? '0 : idx + HW'(1);
  endfunction

  // Several harts can drop in the same cycle, so add the whole vector and clamp.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [NUM_HARTS-1:0] inc_vec);
    logic [16:0] sum;
    sum = {1'b0, a};
    for (int i = 0; i < NUM_HARTS; i++) sum = sum + 17'(inc_vec[i]);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    assign full[h]    = (wr_ptr[h][AW] != rd_ptr[h][AW]) &&
                        (wr_ptr[h][AW-1:0] == rd_ptr[h][AW-1:0]);
    assign empty[h]   = (wr_ptr[h] == rd_ptr[h]);
    assign push[h]    = commit_valid_i[h] && !full[h];
    assign drop[h]    = !STALL_ON_FULL && commit_valid_i[h] && full[h];
    assign seq_inc[h] = STALL_ON_FULL ? push[h] : commit_valid_i[h];
    assign pop[h]     = load && (gnt_idx == HW'(h));
  end

  assign commit_ready_o = ~full;

  // Round-robin scan starting at the priority pointer.
  always_comb begin
    logic [HW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = prio;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!gnt_vld && !empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
      cand = next_idx(cand);
    end
  end

  assign load = (!vld_p1 || out_ready_i) && gnt_vld;

  // Stage p0: per-hart FIFO storage (data only, no reset needed behind the pointers)
  always_ff @(posedge clk_i) begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (push[h]) begin
        fifo_mem[h][wr_ptr[h][AW-1:0]] <= '{pc:   commit_pc_i[64*h +: 64],
                                            data: commit_data_i[64*h +: 64],
                                            dst:  commit_dst_i[5*h +: 5],
                                            xcpt: commit_xcpt_i[h],
                                            seq:  seq_cnt[h]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        wr_ptr[h]  <= '0;
        rd_ptr[h]  <= '0;
        seq_cnt[h] <= '0;
      end
      overflow_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (push[h])    wr_ptr[h]  <= wr_ptr[h] + PW'(1);
        if (pop[h])     rd_ptr[h]  <= rd_ptr[h] + PW'(1);
        if (seq_inc[h]) seq_cnt[h] <= seq_cnt[h] + 16'd1;
      end
      overflow_o <= overflow_o | drop;
      drop_cnt_o <= sat_add16(drop_cnt_o, drop);
    end
  end

  // Stage p1: output register slice, popped FIFO and load happen on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      hart_p1 <= '0;
      rec_p1  <= '0;
      prio    <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      hart_p1 <= gnt_idx;
      rec_p1  <= fifo_mem[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
      prio    <= next_idx(gnt_idx);
    end else if (out_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid_o = vld_p1;
  assign out_hart_o  = hart_p1;
  assign out_pc_o    = rec_p1.pc;
  assign out_data_o  = rec_p1.data;
  assign out_dst_o   = rec_p1.dst;
  assign out_xcpt_o  = rec_p1.xcpt;
  assign out_seq_o   = rec_p1.seq;

endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// Directed bench: a stall-mode and a drop-mode arbiter share one stimulus stream.
module tb_cosim_commit_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   commit_valid;
  logic [127:0] commit_pc, commit_data;
  logic [9:0]   commit_dst;
  logic [1:0]   commit_xcpt;
  logic         out_ready;

  logic [1:0]  s_ready, d_ready, s_ovf, d_ovf;
  logic        s_vld, d_vld, s_xcpt, d_xcpt;
  logic [0:0]  s_hart, d_hart;
  logic [63:0] s_pc, d_pc, s_data, d_data;
  logic [4:0]  s_dst, d_dst;
  logic [15:0] s_seq, d_seq, s_drop, d_drop;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] s_log[$], d_log[$];
  int          s_cnt;
  logic [15:0] s_last;

  always #5 clk = ~clk;

  cosim_commit_arbiter #(.NUM_HARTS(2), .DEPTH(4), .STALL_ON_FULL(1'b1)) u_stall (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(commit_valid), .commit_ready_o(s_ready),
    .commit_pc_i(commit_pc), .commit_data_i(commit_data), .commit_dst_i(commit_dst),
    .commit_xcpt_i(commit_xcpt), .out_valid_o(s_vld), .out_ready_i(out_ready),
    .out_hart_o(s_hart), .out_pc_o(s_pc), .out_data_o(s_data), .out_dst_o(s_dst),
    .out_xcpt_o(s_xcpt), .out_seq_o(s_seq), .overflow_o(s_ovf), .drop_cnt_o(s_drop));

  cosim_commit_arbiter #(.NUM_HARTS(2), .DEPTH(4), .STALL_ON_FULL(1'b0)) u_drop (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(commit_valid), .commit_ready_o(d_ready),
    .commit_pc_i(commit_pc), .commit_data_i(commit_data), .commit_dst_i(commit_dst),
    .commit_xcpt_i(commit_xcpt), .out_valid_o(d_vld), .out_ready_i(out_ready),
    .out_hart_o(d_hart), .out_pc_o(d_pc), .out_data_o(d_data), .out_dst_o(d_dst),
    .out_xcpt_o(d_xcpt), .out_seq_o(d_seq), .overflow_o(d_ovf), .drop_cnt_o(d_drop));

  // Log every record that completes its handshake on the coming edge.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (s_vld) begin
        s_cnt  <= s_cnt + 1;
        s_last <= s_seq;
        if (s_log.size() < 64) s_log.push_back({15'd0, s_hart, s_seq});
      end
      if (d_vld && d_log.size() < 64) d_log.push_back({15'd0, d_hart, d_seq});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    s_log.delete();
    d_log.delete();
    s_cnt  = 0;
    s_last = 16'hDEAD;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    commit_valid = 2'b00;
    step(2);
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst = 1'b1; commit_valid = '0; commit_pc = '0; commit_data = '0;
    commit_dst = '0; commit_xcpt = '0; out_ready = 1'b1;
    s_cnt = 0; s_last = '0;
    do_reset();

    chk("rst_out_valid", 64'(s_vld), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'h3);
    chk("rst_drop_ready", 64'(d_ready), 64'h3);
    chk("rst_drop_cnt", 64'(d_drop), 64'd0);
    chk("rst_overflow", 64'(d_ovf), 64'd0);
    chk("rst_out_pc", s_pc, 64'd0);

    // Single push on hart 0
    commit_valid = 2'b01;
    commit_pc[63:0] = 64'h8000_0000; commit_data[63:0] = 64'h5; commit_dst[4:0] = 5'd3;
    step(1);
    commit_valid = 2'b00;
    chk("single_lat_e1", 64'(s_vld), 64'd0);
    step(1);
    chk("single_valid", 64'(s_vld), 64'd1);
    chk("single_hart", 64'(s_hart), 64'd0);
    chk("single_seq", 64'(s_seq), 64'd0);
    chk("single_pc", s_pc, 64'h8000_0000);
    chk("single_data", s_data, 64'h5);
    chk("single_dst", 64'(s_dst), 64'd3);
    chk("single_xcpt", 64'(s_xcpt), 64'd0);
    step(1);
    chk("single_empty", 64'(s_vld), 64'd0);

    // Fairness: both harts push four records on the same cycles
    do_reset();
    commit_valid = 2'b11;
    step(4);
    commit_valid = 2'b00;
    step(12);
    chk("fair_count", 64'(s_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < s_log.size(); i++)
      chk($sformatf("fair_rec%0d", i), 64'(s_log[i]), 64'(((i % 2) << 16) | (i / 2)));

    // Backpressure (stall) and drop on hart 1 with the output blocked
    do_reset();
    out_ready = 1'b0;
    commit_valid = 2'b10;
    commit_pc[127:64] = 64'h0000_1234_0000_0000;
    step(8);
    commit_valid = 2'b00;
    chk("bp_ready", 64'(s_ready), 64'h1);
    chk("bp_valid", 64'(s_vld), 64'd1);
    chk("bp_seq", 64'(s_seq), 64'd0);
    chk("bp_hart", 64'(s_hart), 64'd1);
    step(3);
    chk("bp_stable_seq", 64'(s_seq), 64'd0);
    chk("bp_stable_pc", s_pc, 64'h0000_1234_0000_0000);
    chk("bp_no_overflow", 64'(s_ovf), 64'd0);
    chk("drop_overflow", 64'(d_ovf), 64'h2);
    chk("drop_cnt", 64'(d_drop), 64'd3);
    out_ready = 1'b1;
    step(8);
    chk("bp_count", 64'(s_log.size()), 64'd5);
    chk("drop_count", 64'(d_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < s_log.size(); i++)
      chk($sformatf("bp_rec%0d", i), 64'(s_log[i]), 64'((1 << 16) | i));
    for (int i = 0; i < 5 && i < d_log.size(); i++)
      chk($sformatf("drop_rec%0d", i), 64'(d_log[i]), 64'((1 << 16) | i));
    clear_logs();
    commit_valid = 2'b10;
    step(1);
    commit_valid = 2'b00;
    step(4);
    chk("drop_next_n", 64'(d_log.size()), 64'd1);
    if (d_log.size() > 0) chk("drop_next_seq", 64'(d_log[0]), 64'h1_0008);
    if (s_log.size() > 0) chk("bp_next_seq", 64'(s_log[0]), 64'h1_0005);

    // Reset in the middle of buffered traffic, with a commit present during reset
    out_ready = 1'b0;
    commit_valid = 2'b01;
    step(4);
    chk("mid_valid_before", 64'(s_vld), 64'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    commit_valid = 2'b00;
    chk("mid_valid", 64'(s_vld), 64'd0);
    chk("mid_overflow", 64'(d_ovf), 64'd0);
    chk("mid_drop_cnt", 64'(d_drop), 64'd0);
    chk("mid_ready", 64'(s_ready), 64'h3);
    clear_logs();
    out_ready = 1'b1;
    step(4);
    chk("mid_no_stale", 64'(s_log.size()), 64'd0);
    commit_valid = 2'b01;
    step(1);
    commit_valid = 2'b00;
    step(3);
    chk("mid_next_n", 64'(s_log.size()), 64'd1);
    if (s_log.size() > 0) chk("mid_next_seq", 64'(s_log[0]), 64'h0);

    // Sequence wrap: 65537 records on hart 0
    do_reset();
    commit_valid = 2'b01;
    step(65537);
    commit_valid = 2'b00;
    step(5);
    chk("wrap_count", 64'(s_cnt), 64'd65537);
    chk("wrap_last_seq", 64'(s_last), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cosim_commit_arbiter.md
COSIM_COMMIT_ARBITER -- requirements
Module: cosim_commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 2: number of commit channels, range 1..8.
REQ-002 SHALL have parameter DEPTH, default 4: per-hart FIFO entries, power of two, 2..16.
REQ-003 SHALL have parameter STALL_ON_FULL, default 1: 1 = backpressure via commit_ready_o; 0 = drop on full.
REQ-004 SHALL have HW = max(1, clog2(NUM_HARTS)) as derived hart-index width.
REQ-005 SHALL have port clk_i  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port commit_valid_i  in  NUM_HARTS  per-hart retire strobe.
REQ-008 SHALL have port commit_ready_o  out  NUM_HARTS  per-hart FIFO not full.
REQ-009 SHALL have ports commit_pc_i / commit_data_i  in  NUM_HARTS*64 each  packed, hart h at bits [64h+63:64h].
REQ-010 SHALL have port commit_dst_i  in  NUM_HARTS*5  destination GPR index; commit_xcpt_i  in  NUM_HARTS  exception flag.
REQ-011 SHALL have port out_valid_o  in/out handshake with out_ready_i  in  1.
REQ-012 SHALL have ports out_hart_o HW, out_pc_o 64, out_data_o 64, out_dst_o 5, out_xcpt_o 1, out_seq_o 16: record fields.
REQ-013 SHALL have port overflow_o  out  NUM_HARTS  sticky per-hart drop flag; drop_cnt_o  out  16  total dropped records, saturating.

Function
REQ-014 Record accepted on hart h when commit_valid_i[h] && !full[h]; written into FIFO h at that edge.
REQ-015 commit_ready_o[h] = !full[h], combinational from FIFO state only, no dependency on commit_valid_i.
REQ-016 Full FIFO + commit_valid_i[h]: STALL_ON_FULL=1 -> record not accepted, source holds; STALL_ON_FULL=0 -> record discarded, overflow_o[h] set, drop_cnt_o +1 (saturate at 0xFFFF).
REQ-017 Full-FIFO push rejected even if the same FIFO pops that cycle; no write-through-on-pop.
REQ-018 Per-hart 16-bit seq counter increments on every cycle commit_valid_i[h]=1 in drop mode (accepted or dropped); in stall mode only on accept; wraps 0xFFFF->0; stored value is pre-increment count.
REQ-019 Output stage: one register slice; loads when (!out_valid_o || out_ready_i) and at least one FIFO non-empty.
REQ-020 Arbitration round-robin: priority pointer p; grant first non-empty hart scanning p, p+1, ... mod NUM_HARTS; on load p <= granted+1 mod NUM_HARTS; p unchanged when no load.
REQ-021 Granted FIFO popped on the same edge the output register loads.
REQ-022 Min latency: commit accepted at edge N -> out_valid_o=1 after edge N+1 (FIFO not bypassed).
REQ-023 out_* fields SHALL remain stable while out_valid_o && !out_ready_i.
REQ-024 out_valid_o && out_ready_i with nothing pending -> out_valid_o=0 next cycle; with pending -> back-to-back, one record per cycle.
REQ-025 Per-hart order SHALL be preserved; no record duplicated or lost except REQ-016 drops.
REQ-026 FIFO pointers log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ & rest equal; empty = equal.

Reset
REQ-027 rst_i at a clock edge SHALL clear all FIFOs, seq counters, p=0, overflow_o=0, drop_cnt_o=0, out_valid_o=0, out fields=0; commit_ready_o all 1 the cycle after.
REQ-028 Reset mid-transfer SHALL discard buffered and held records; no record emitted post-reset from pre-reset pushes; rst_i overrides simultaneous commits.

Verification
REQ-029 Single push: hart 0 pc=0x8000_0000, data=0x5, dst=3 at edge 1, out_ready_i=1 -> after edge 2 out_valid_o=1, out_hart_o=0, out_seq_o=0, fields match; cycle after out_valid_o=0.
REQ-030 Fairness: NUM_HARTS=2, both harts push 4 records same cycles, out_ready_i=1 -> output alternates hart 0,1,0,1... 8 records, per-hart seq 0..3 in order.
REQ-031 Backpressure: STALL_ON_FULL=1, DEPTH=4, out_ready_i=0, hart 1 valid continuously -> 5 accepted (4 FIFO + 1 output reg), commit_ready_o[1]=0 afterward, out fields stable; release -> all 5 emitted, seq 0..4.
REQ-032 Drop: STALL_ON_FULL=0, same stimulus 8 cycles -> overflow_o[1]=1, drop_cnt_o=3, emitted seq 0,1,2,3,4 with no gaps; next accepted record seq=8.
REQ-033 Seq wrap: 65537 accepted on hart 0 -> last record out_seq_o=0x0000.
REQ-034 Reset mid-operation: 3 records buffered, out_valid_o=1, rst_i one cycle -> out_valid_o=0, overflow_o=0, drop_cnt_o=0; next push emits seq=0.
